// File: rtl/eth_ram_hdmi_reader.sv
// Read side of the Ethernet-to-HDMI ping-pong frame buffer: drains one full bank
// through the 1-cycle-latency RAM read port into a valid/ready pixel stream.
module eth_ram_hdmi_reader #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 16,
    parameter int BANK_WORDS = 4096
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic [1:0]            bank_rdy,
    output logic [1:0]            bank_rel,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy
);

    localparam int            CW       = ADDR_WIDTH - 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(BANK_WORDS - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, RELEASE} state_t;

    state_t                state, state_nxt;
    logic                  cur_bank;
    logic [CW-1:0]         word_cnt;
    logic                  issue, start;

    // Two-stage in-flight tracker: stage 1 = address registered, stage 2 = RAM sampled.
    logic                  v1, v1_last, v2, v2_last;
    logic [1:0]            inflight;

    logic [DATA_WIDTH-1:0] fifo_data [4];
    logic [3:0]            fifo_last;
    logic [1:0]            wr_ptr, rd_ptr;
    logic [2:0]            fifo_count;
    logic                  push, pop;

    assign inflight = {1'b0, v1} + {1'b0, v2};
    assign push     = v2;
    assign m_valid  = (fifo_count != 3'd0);
    assign pop      = m_valid & m_ready;
    assign m_data   = fifo_data[rd_ptr];
    assign m_last   = fifo_last[rd_ptr];
    assign busy     = (state != IDLE);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        issue     = 1'b0;
        start     = 1'b0;
        bank_rel  = 2'b00;
        case (state)
            IDLE: begin
                if (bank_rdy[cur_bank]) begin
                    start     = 1'b1;
                    state_nxt = READ;
                end
            end
            READ: begin
                // Credit covers both FIFO occupancy and words still in the RAM pipeline.
                if ((fifo_count + {1'b0, inflight}) < 3'd4) begin
                    issue = 1'b1;
                    if (word_cnt == LAST_IDX) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight == 2'd0 && fifo_count == 3'd0) state_nxt = RELEASE;
            end
            RELEASE: begin
                bank_rel[cur_bank] = 1'b1;
                state_nxt          = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            cur_bank   <= 1'b0;
            word_cnt   <= '0;
            rd_addr    <= '0;
            v1         <= 1'b0;
            v1_last    <= 1'b0;
            v2         <= 1'b0;
            v2_last    <= 1'b0;
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 3'd0;
            fifo_last  <= 4'd0;
            // NOTE: the 4-entry FIFO storage is reset so m_data reads 0 straight out of reset.
            for (int i = 0; i < 4; i++) fifo_data[i] <= '0;
        end else begin
            if (start) begin
                word_cnt <= '0;
            end else if (issue && word_cnt != LAST_IDX) begin
                word_cnt <= word_cnt + CW'(1);
            end
            if (issue) rd_addr <= {cur_bank, word_cnt};

            v1      <= issue;
            v1_last <= issue && (word_cnt == LAST_IDX);
            v2      <= v1;
            v2_last <= v1_last;

            if (push) begin
                fifo_data[wr_ptr] <= rd_data;
                fifo_last[wr_ptr] <= v2_last;
                wr_ptr            <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase

            if (state == RELEASE) cur_bank <= ~cur_bank;
        end
    end

endmodule

// File: tb/tb_eth_ram_hdmi_reader.sv
// Scoreboard bench for eth_ram_hdmi_reader: a behavioural RAM feeds the DUT and every
// accepted stream word is popped against an expected queue filled when a bank is offered.
module tb_eth_ram_hdmi_reader;

    localparam int AW = 13;
    localparam int DW = 16;
    localparam int BW = 4096;
    localparam int CW = AW - 1;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (BANK_WORDS = 4096)
    logic          rd_rst = 1'b1;
    logic [1:0]    bank_rdy = 2'b00;
    logic [1:0]    bank_rel;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;
    logic          busy;

    // Single-word DUT (BANK_WORDS = 1)
    logic          rst1 = 1'b1;
    logic [1:0]    bank_rdy1 = 2'b00;
    logic [1:0]    bank_rel1;
    logic [AW-1:0] rd_addr1;
    logic [DW-1:0] rd_data1 = '0;
    logic [DW-1:0] m_data1;
    logic          m_valid1;
    logic          m_ready1 = 1'b1;
    logic          m_last1;
    logic          busy1;

    eth_ram_hdmi_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_WORDS(BW)) dut (
        .rd_clk(clk), .rd_rst(rd_rst), .bank_rdy(bank_rdy), .bank_rel(bank_rel),
        .rd_addr(rd_addr), .rd_data(rd_data), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .busy(busy)
    );

    eth_ram_hdmi_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_WORDS(1)) dut1 (
        .rd_clk(clk), .rd_rst(rst1), .bank_rdy(bank_rdy1), .bank_rel(bank_rel1),
        .rd_addr(rd_addr1), .rd_data(rd_data1), .m_data(m_data1), .m_valid(m_valid1),
        .m_ready(m_ready1), .m_last(m_last1), .busy(busy1)
    );

    // Frame buffer RAM: synchronous read, data valid after the sampling edge.
    logic [DW-1:0] mem [2**AW];
    always @(posedge clk) begin
        rd_data  <= mem[rd_addr];
        rd_data1 <= mem[rd_addr1];
    end

    int      n_cmp = 0;
    int      n_err = 0;
    int      hs_count = 0;
    word_t   exp_q[$];
    word_t   exp_w;
    bit      mon_en = 1'b0;
    bit      addr_chk = 1'b0;
    logic    exp_bank = 1'b0;
    logic    stall_prev = 1'b0;
    word_t   held;
    logic [AW-1:0] prev_addr = '0;

    // Stream monitor, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (mon_en && !rd_rst) begin
            if (stall_prev) begin
                n_cmp++;
                if (m_valid !== 1'b1 || {m_last, m_data} !== held) begin
                    n_err++;
                    $display("FAIL stall_hold: got valid=%b word=%h, required valid=1 word=%h",
                             m_valid, {m_last, m_data}, held);
                end
            end
            if (m_valid && m_ready) begin
                hs_count++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_word: got word=%h, required none", {m_last, m_data});
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({m_last, m_data} !== exp_w) begin
                        n_err++;
                        $display("FAIL stream_word: got last=%b data=%h, required last=%b data=%h",
                                 m_last, m_data, exp_w.last, exp_w.data);
                    end
                end
            end
            n_cmp++;
            if (dut.fifo_count > 3'd4) begin
                n_err++;
                $display("FAIL fifo_bound: got count=%0d, required <=4", dut.fifo_count);
            end
            if (addr_chk && rd_addr !== prev_addr) begin
                n_cmp++;
                if (rd_addr[AW-1] !== exp_bank) begin
                    n_err++;
                    $display("FAIL addr_bank: got addr=%h, required bank %0d", rd_addr, exp_bank);
                end
            end
            stall_prev = m_valid && !m_ready;
            held       = {m_last, m_data};
        end else begin
            stall_prev = 1'b0;
        end
        prev_addr = rd_addr;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_bank(input logic b);
        word_t w;
        for (int i = 0; i < BW; i++) begin
            w.last = (i == BW - 1);
            w.data = mem[{b, CW'(i)}];
            exp_q.push_back(w);
        end
    endtask

    // Runs until bank_rel rises or the budget expires, measuring the valid run.
    task automatic stream_bank(input int budget, input bit rand_ready, output int run,
                               output bit broken, output int t_last, output int t_rel,
                               output logic [1:0] rel);
        bit gap;
        gap = 1'b0; run = 0; broken = 1'b0; t_last = -1; t_rel = -1; rel = 2'b00;
        for (int c = 0; c < budget; c++) begin
            if (m_valid) begin
                if (gap) broken = 1'b1;
                run++;
                if (m_last) t_last = c;
            end else if (run > 0) begin
                gap = 1'b1;
            end
            if (bank_rel !== 2'b00) begin
                t_rel = c;
                rel   = bank_rel;
                break;
            end
            tick();
            if (rand_ready) m_ready = ($urandom_range(0, 99) < 30);
        end
    endtask

    task automatic test_reset;
        rd_rst = 1'b1; mon_en = 1'b0; bank_rdy = 2'b00; m_ready = 1'b0;
        tick(); tick();
        n_cmp++; if (rd_addr !== '0)     begin n_err++; $display("FAIL rst_addr: got %h want 0", rd_addr); end
        n_cmp++; if (bank_rel !== 2'b00) begin n_err++; $display("FAIL rst_rel: got %b want 00", bank_rel); end
        n_cmp++; if (m_valid !== 1'b0)   begin n_err++; $display("FAIL rst_valid: got %b want 0", m_valid); end
        n_cmp++; if (m_data !== '0)      begin n_err++; $display("FAIL rst_data: got %h want 0", m_data); end
        n_cmp++; if (m_last !== 1'b0)    begin n_err++; $display("FAIL rst_last: got %b want 0", m_last); end
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        rd_rst = 1'b0;
        tick();
    endtask

    task automatic test_bank0_stream;
        int run, t_last, t_rel;
        bit broken;
        logic [1:0] rel;
        mon_en = 1'b1; addr_chk = 1'b1; exp_bank = 1'b0; m_ready = 1'b1;
        push_bank(1'b0);
        bank_rdy = 2'b01;
        tick();
        n_cmp++; if (busy !== 1'b1)    begin n_err++; $display("FAIL b0_busy: got %b want 1", busy); end
        tick();
        n_cmp++; if (rd_addr !== '0)   begin n_err++; $display("FAIL b0_first_addr: got %h want 0", rd_addr); end
        tick();
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL b0_early_valid: got %b want 0", m_valid); end
        tick();
        n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL b0_latency: got %b want 1", m_valid); end
        stream_bank(6000, 1'b0, run, broken, t_last, t_rel, rel);
        n_cmp++; if (rel !== 2'b01)    begin n_err++; $display("FAIL b0_release: got %b want 01", rel); end
        n_cmp++; if (run != BW)        begin n_err++; $display("FAIL b0_valid_run: got %0d want %0d", run, BW); end
        n_cmp++; if (broken)           begin n_err++; $display("FAIL b0_valid_gap: got gap want none"); end
        n_cmp++; if (t_rel - t_last != 2) begin n_err++; $display("FAIL b0_rel_timing: got %0d want 2", t_rel - t_last); end
        tick();
        n_cmp++; if (bank_rel !== 2'b00) begin n_err++; $display("FAIL b0_rel_width: got %b want 00", bank_rel); end
        n_cmp++; if (exp_q.size() != 0)  begin n_err++; $display("FAIL b0_left: got %0d want 0", exp_q.size()); end
        bank_rdy = 2'b00;
        tick();
    endtask

    task automatic test_bank1_stream;
        int run, t_last, t_rel;
        bit broken;
        logic [1:0] rel;
        exp_bank = 1'b1;
        push_bank(1'b1);
        bank_rdy = 2'b10;
        tick();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b1_busy: got %b want 1", busy); end
        tick();
        n_cmp++; if (rd_addr !== 13'h1000) begin n_err++; $display("FAIL b1_first_addr: got %h want 1000", rd_addr); end
        stream_bank(6000, 1'b0, run, broken, t_last, t_rel, rel);
        n_cmp++; if (rel !== 2'b10) begin n_err++; $display("FAIL b1_release: got %b want 10", rel); end
        n_cmp++; if (run != BW)     begin n_err++; $display("FAIL b1_valid_run: got %0d want %0d", run, BW); end
        n_cmp++; if (broken)        begin n_err++; $display("FAIL b1_valid_gap: got gap want none"); end
        tick();
        n_cmp++; if (bank_rel !== 2'b00) begin n_err++; $display("FAIL b1_rel_width: got %b want 00", bank_rel); end
        n_cmp++; if (exp_q.size() != 0)  begin n_err++; $display("FAIL b1_left: got %0d want 0", exp_q.size()); end
        bank_rdy = 2'b00;
        tick();
    endtask

    task automatic test_random_ready;
        int run, t_last, t_rel, hs0;
        bit broken;
        logic [1:0] rel;
        exp_bank = 1'b0;
        hs0 = hs_count;
        push_bank(1'b0);
        bank_rdy = 2'b01;
        m_ready  = 1'b0;
        stream_bank(20000, 1'b1, run, broken, t_last, t_rel, rel);
        n_cmp++; if (rel !== 2'b01) begin n_err++; $display("FAIL rnd_release: got %b want 01", rel); end
        n_cmp++; if (hs_count - hs0 != BW) begin n_err++; $display("FAIL rnd_handshakes: got %0d want %0d", hs_count - hs0, BW); end
        n_cmp++; if (exp_q.size() != 0)    begin n_err++; $display("FAIL rnd_left: got %0d want 0", exp_q.size()); end
        m_ready  = 1'b1;
        bank_rdy = 2'b00;
        tick();
    endtask

    task automatic test_wrong_bank;
        int hs0;
        bit reached;
        rd_rst = 1'b1; mon_en = 1'b0;
        tick(); tick();
        rd_rst = 1'b0;
        exp_q.delete();
        bank_rdy = 2'b10;
        mon_en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL wrong_bank_busy: got %b want 0", busy); end
            n_cmp++; if (rd_addr !== '0) begin n_err++; $display("FAIL wrong_bank_addr: got %h want 0", rd_addr); end
        end
        exp_bank = 1'b0;
        push_bank(1'b0);
        hs0 = hs_count;
        bank_rdy = 2'b11;
        tick();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL wrong_bank_start: got %b want 1", busy); end
        reached = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (hs_count - hs0 >= 100) begin
                reached = 1'b1;
                break;
            end
            tick();
        end
        n_cmp++; if (!reached) begin n_err++; $display("FAIL words_100: got %0d want 100", hs_count - hs0); end
    endtask

    task automatic test_mid_reset;
        int run, t_last, t_rel;
        bit broken;
        logic [1:0] rel;
        rd_rst = 1'b1; mon_en = 1'b0;
        tick();
        n_cmp++; if (rd_addr !== '0)     begin n_err++; $display("FAIL mid_rst_addr: got %h want 0", rd_addr); end
        n_cmp++; if (bank_rel !== 2'b00) begin n_err++; $display("FAIL mid_rst_rel: got %b want 00", bank_rel); end
        n_cmp++; if (m_valid !== 1'b0)   begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", m_valid); end
        n_cmp++; if (m_data !== '0)      begin n_err++; $display("FAIL mid_rst_data: got %h want 0", m_data); end
        n_cmp++; if (m_last !== 1'b0)    begin n_err++; $display("FAIL mid_rst_last: got %b want 0", m_last); end
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        exp_q.delete();
        rd_rst   = 1'b0;
        bank_rdy = 2'b01;
        exp_bank = 1'b0;
        push_bank(1'b0);
        mon_en = 1'b1;
        tick(); tick();
        n_cmp++; if (rd_addr !== 13'h0000) begin n_err++; $display("FAIL restart_addr0: got %h want 0", rd_addr); end
        tick();
        n_cmp++; if (rd_addr !== 13'h0001) begin n_err++; $display("FAIL restart_addr1: got %h want 1", rd_addr); end
        stream_bank(6000, 1'b0, run, broken, t_last, t_rel, rel);
        n_cmp++; if (rel !== 2'b01) begin n_err++; $display("FAIL restart_release: got %b want 01", rel); end
        n_cmp++; if (run != BW)     begin n_err++; $display("FAIL restart_run: got %0d want %0d", run, BW); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL restart_left: got %0d want 0", exp_q.size()); end
        bank_rdy = 2'b00;
        tick();
    endtask

    task automatic test_single_word;
        word_t q1[$];
        word_t w, e;
        int nvalid, valid_cyc, rel_cyc, nrel;
        logic [1:0] rel_val;
        logic [AW-1:0] addr_at2;
        rst1 = 1'b1;
        tick(); tick();
        rst1 = 1'b0;
        tick();
        for (int b = 0; b < 2; b++) begin
            w.last = 1'b1;
            w.data = mem[{b[0], CW'(0)}];
            q1.push_back(w);
            nvalid = 0; valid_cyc = -1; rel_cyc = -1; nrel = 0; rel_val = 2'b00; addr_at2 = '0;
            bank_rdy1 = (b == 0) ? 2'b01 : 2'b10;
            for (int c = 1; c <= 12; c++) begin
                tick();
                if (c == 2) addr_at2 = rd_addr1;
                if (m_valid1) begin
                    nvalid++;
                    if (nvalid == 1) begin
                        valid_cyc = c;
                        e = q1.pop_front();
                        n_cmp++;
                        if ({m_last1, m_data1} !== e) begin
                            n_err++;
                            $display("FAIL bw1_word: got last=%b data=%h, required last=%b data=%h",
                                     m_last1, m_data1, e.last, e.data);
                        end
                    end
                end
                if (bank_rel1 !== 2'b00) begin
                    nrel++;
                    if (rel_cyc < 0) begin rel_cyc = c; rel_val = bank_rel1; end
                end
            end
            n_cmp++; if (addr_at2 !== {b[0], CW'(0)}) begin n_err++; $display("FAIL bw1_addr: got %h want %h", addr_at2, {b[0], CW'(0)}); end
            n_cmp++; if (nvalid != 1)    begin n_err++; $display("FAIL bw1_nvalid: got %0d want 1", nvalid); end
            n_cmp++; if (valid_cyc != 4) begin n_err++; $display("FAIL bw1_latency: got %0d want 4", valid_cyc); end
            n_cmp++; if (rel_val !== bank_rdy1) begin n_err++; $display("FAIL bw1_release: got %b want %b", rel_val, bank_rdy1); end
            n_cmp++; if (rel_cyc != 6)   begin n_err++; $display("FAIL bw1_rel_timing: got %0d want 6", rel_cyc); end
            n_cmp++; if (nrel != 1)      begin n_err++; $display("FAIL bw1_rel_width: got %0d want 1", nrel); end
            bank_rdy1 = 2'b00;
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) mem[i] = DW'(i);
        test_reset();
        test_bank0_stream();
        test_bank1_stream();
        test_random_ready();
        test_wrong_bank();
        test_mid_reset();
        test_single_word();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
